// File: rtl/gbc_video_pkg.sv
// ============================================================================
// Module   : gbc_video_pkg
// Purpose  : Shared types, address-space tags, register offsets and reset
//            values for the GBC video memory Wishbone target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gbc_video_pkg;

  // Address-space tags carried on wb_tga_i
  localparam logic [1:0] TGA_VRAM    = 2'b00;
  localparam logic [1:0] TGA_OAM     = 2'b01;
  localparam logic [1:0] TGA_REGS    = 2'b10;
  localparam logic [1:0] TGA_INVALID = 2'b11;

  // Register offsets (low address byte)
  localparam logic [7:0] REG_LCDC = 8'h40;
  localparam logic [7:0] REG_STAT = 8'h41;
  localparam logic [7:0] REG_SCY  = 8'h42;
  localparam logic [7:0] REG_SCX  = 8'h43;
  localparam logic [7:0] REG_LY   = 8'h44;
  localparam logic [7:0] REG_LYC  = 8'h45;
  localparam logic [7:0] REG_DMA  = 8'h46;
  localparam logic [7:0] REG_BGP  = 8'h47;
  localparam logic [7:0] REG_OBP0 = 8'h48;
  localparam logic [7:0] REG_OBP1 = 8'h49;
  localparam logic [7:0] REG_WY   = 8'h4A;
  localparam logic [7:0] REG_WX   = 8'h4B;
  localparam logic [7:0] REG_BCPS = 8'h68;
  localparam logic [7:0] REG_BCPD = 8'h69;
  localparam logic [7:0] REG_OCPS = 8'h6A;
  localparam logic [7:0] REG_OCPD = 8'h6B;

  // OAM holds 40 sprites x 4 bytes
  localparam logic [7:0] OAM_SIZE = 8'hA0;

  // Register reset values
  localparam logic [7:0] LCDC_RESET = 8'h91;
  localparam logic [7:0] BGP_RESET  = 8'hFC;

  // Live register file handed to the PPU; stat keeps only its writable bits
  typedef struct packed {
    logic [7:0] lcdc;
    logic [7:0] stat;
    logic [7:0] scy;
    logic [7:0] scx;
    logic [7:0] lyc;
    logic [7:0] dma;
    logic [7:0] bgp;
    logic [7:0] obp0;
    logic [7:0] obp1;
    logic [7:0] wy;
    logic [7:0] wx;
  } video_regs_t;

  // Source of the read data presented during the ack cycle
  typedef enum logic [2:0] {
    SRC_ZERO = 3'd0,
    SRC_REG  = 3'd1,
    SRC_VRAM = 3'd2,
    SRC_OAM  = 3'd3,
    SRC_BGPD = 3'd4,
    SRC_OBPD = 3'd5
  } rd_src_e;

  // Transfer state: idle or second cycle of a VRAM-to-OAM copy
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DMA_COPY = 1'b1
  } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/gbc_palette_ram.sv
// ============================================================================
// Module   : gbc_palette_ram
// Purpose  : One CGB palette: index/auto-increment register (xCPS) plus the
//            64x8 palette RAM reached through the data port (xCPD).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gbc_palette_ram (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_index,
  input  logic       sel_data,
  input  logic       we,
  input  logic       locked,
  input  logic [7:0] wdata,
  output logic [7:0] index_q,
  output logic [7:0] data_q
);

  logic       auto_inc;
  logic [5:0] index;
  logic [7:0] mem [0:63];
  logic [7:0] rd_q;
  logic       locked_q;

  // Index register: loaded by xCPS writes, bumped by xCPD writes even while locked
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_inc <= 1'b0;
      index    <= 6'd0;
    end else if (sel_index && we) begin
      auto_inc <= wdata[7];
      index    <= wdata[5:0];
    end else if (sel_data && we && auto_inc) begin
      index    <= index + 6'd1;
    end
  end

  // Single-port palette RAM, read-first; contents survive reset
  always_ff @(posedge clk) begin
    if (sel_data && we && !locked) begin
      mem[index] <= wdata;
    end
    rd_q <= mem[index];
  end

  // Remember whether the access cycle was locked out by mode 3
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked;
    end
  end

  assign index_q = {auto_inc, 1'b1, index};
  assign data_q  = locked_q ? 8'hFF : rd_q;

endmodule

`default_nettype wire

// File: rtl/gbc_video_memory_target.sv
// ============================================================================
// Module   : gbc_video_memory_target
// Purpose  : Wishbone target exposing VRAM, OAM, LCD registers and CGB
//            palettes, with PPU-mode access blocking and OAM DMA support.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gbc_video_memory_target
  import gbc_video_pkg::*;
#(
  parameter int VRAM_BANKS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [13:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  input  logic [1:0]  wb_tga_i,
  input  logic        wb_tgc_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  input  logic [1:0]  ppu_mode_i,
  input  logic [7:0]  ly_i,
  output video_regs_t regs_o
);

  localparam int VRAM_AW    = (VRAM_BANKS == 2) ? 14 : 13;
  localparam int VRAM_DEPTH = 1 << VRAM_AW;

  dma_state_e  state;
  rd_src_e     src;
  video_regs_t regs;
  logic [7:0]  reg_q;
  logic [7:0]  reg_rd;
  logic [7:0]  dma_idx;
  logic [7:0]  idx;
  logic        accept;
  logic        mode3;
  logic        oam_blocked;
  logic        oam_in_range;
  logic        is_vram, is_oam, is_dma_wr, is_dma_copy, is_reg;

  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram [0:VRAM_DEPTH-1];
  logic [7:0]         vram_q;
  logic               vram_we;

  logic [7:0] oam [0:159];
  logic [7:0] oam_q;
  logic [7:0] oam_addr;
  logic [7:0] oam_wdata;
  logic       oam_we;
  logic       copy_commit;

  logic [7:0] bg_index_q, bg_data_q, obj_index_q, obj_data_q;

  assign accept       = wb_cyc_i & wb_stb_i & ~wb_stall_o & ~reset;
  assign idx          = wb_adr_i[7:0];
  assign mode3        = (ppu_mode_i == 2'd3);
  assign oam_blocked  = ppu_mode_i[1];
  assign oam_in_range = (idx < OAM_SIZE);

  assign is_vram     = accept & (wb_tga_i == TGA_VRAM) & ~wb_tgc_i;
  assign is_dma_copy = accept & (wb_tga_i == TGA_VRAM) &  wb_tgc_i;
  assign is_oam      = accept & (wb_tga_i == TGA_OAM)  & ~wb_tgc_i;
  assign is_dma_wr   = accept & (wb_tga_i == TGA_OAM)  &  wb_tgc_i;
  assign is_reg      = accept & (wb_tga_i == TGA_REGS);

  // With a single bank the bank-select address bit is simply not wired
  generate
    if (VRAM_BANKS == 2) begin : g_two_banks
      assign vram_addr = wb_adr_i;
    end else begin : g_one_bank
      assign vram_addr = wb_adr_i[12:0];
    end
  endgenerate

  assign vram_we = is_vram & wb_we_i & ~mode3;

  // VRAM single-port RAM, read-first
  always_ff @(posedge clk) begin
    if (vram_we) begin
      vram[vram_addr] <= wb_dat_i;
    end
    vram_q <= vram[vram_addr];
  end

  // The copy cycle owns the OAM port; no new request is accepted while it runs
  assign copy_commit = (state == ST_DMA_COPY) & ~reset & (dma_idx < OAM_SIZE);
  assign oam_addr    = (state == ST_DMA_COPY) ? dma_idx : idx;
  assign oam_wdata   = (state == ST_DMA_COPY) ? vram_q  : wb_dat_i;
  assign oam_we      = copy_commit
                     | (is_oam & wb_we_i & oam_in_range & ~oam_blocked)
                     | (is_dma_wr & oam_in_range);

  // OAM single-port RAM, out-of-range indices never touch the array
  always_ff @(posedge clk) begin
    if (oam_we) begin
      oam[oam_addr] <= oam_wdata;
    end
    if (oam_addr < OAM_SIZE) begin
      oam_q <= oam[oam_addr];
    end
  end

  gbc_palette_ram u_bg_palette (
    .clk       (clk),
    .reset     (reset),
    .sel_index (is_reg && (idx == REG_BCPS)),
    .sel_data  (is_reg && (idx == REG_BCPD)),
    .we        (wb_we_i),
    .locked    (mode3),
    .wdata     (wb_dat_i),
    .index_q   (bg_index_q),
    .data_q    (bg_data_q)
  );

  gbc_palette_ram u_obj_palette (
    .clk       (clk),
    .reset     (reset),
    .sel_index (is_reg && (idx == REG_OCPS)),
    .sel_data  (is_reg && (idx == REG_OCPD)),
    .we        (wb_we_i),
    .locked    (mode3),
    .wdata     (wb_dat_i),
    .index_q   (obj_index_q),
    .data_q    (obj_data_q)
  );

  // Register read value for the current address, composed from live state
  always_comb begin
    reg_rd = 8'hFF;
    case (idx)
      REG_LCDC: reg_rd = regs.lcdc;
      REG_STAT: reg_rd = {1'b1, regs.stat[6:3], (ly_i == regs.lyc), ppu_mode_i};
      REG_SCY:  reg_rd = regs.scy;
      REG_SCX:  reg_rd = regs.scx;
      REG_LY:   reg_rd = ly_i;
      REG_LYC:  reg_rd = regs.lyc;
      REG_DMA:  reg_rd = regs.dma;
      REG_BGP:  reg_rd = regs.bgp;
      REG_OBP0: reg_rd = regs.obp0;
      REG_OBP1: reg_rd = regs.obp1;
      REG_WY:   reg_rd = regs.wy;
      REG_WX:   reg_rd = regs.wx;
      REG_BCPS: reg_rd = bg_index_q;
      REG_OCPS: reg_rd = obj_index_q;
      default:  reg_rd = 8'hFF;
    endcase
  end

  // LCD register file writes; LY and unmapped offsets ignore writes
  always_ff @(posedge clk) begin
    if (reset) begin
      regs      <= '0;
      regs.lcdc <= LCDC_RESET;
      regs.bgp  <= BGP_RESET;
    end else if (is_reg && wb_we_i) begin
      case (idx)
        REG_LCDC: regs.lcdc <= wb_dat_i;
        REG_STAT: regs.stat <= {1'b0, wb_dat_i[6:3], 3'b000};
        REG_SCY:  regs.scy  <= wb_dat_i;
        REG_SCX:  regs.scx  <= wb_dat_i;
        REG_LYC:  regs.lyc  <= wb_dat_i;
        REG_DMA:  regs.dma  <= wb_dat_i;
        REG_BGP:  regs.bgp  <= wb_dat_i;
        REG_OBP0: regs.obp0 <= wb_dat_i;
        REG_OBP1: regs.obp1 <= wb_dat_i;
        REG_WY:   regs.wy   <= wb_dat_i;
        REG_WX:   regs.wx   <= wb_dat_i;
        default:  ;
      endcase
    end
  end

  assign regs_o = regs;

  // Bus response FSM: one-cycle ack, or stall + ack for VRAM-to-OAM copies
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wb_ack_o   <= 1'b0;
      wb_stall_o <= 1'b0;
      src        <= SRC_ZERO;
      reg_q      <= 8'h00;
      dma_idx    <= 8'h00;
    end else begin
      wb_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_dma_copy) begin
              state      <= ST_DMA_COPY;
              wb_stall_o <= 1'b1;
              dma_idx    <= idx;
            end else begin
              wb_ack_o   <= 1'b1;
            end
            case (wb_tga_i)
              TGA_VRAM: begin
                src   <= (mode3 && !wb_tgc_i) ? SRC_REG : SRC_VRAM;
                reg_q <= 8'hFF;
              end
              TGA_OAM: begin
                if (wb_tgc_i) begin
                  src   <= SRC_REG;
                  reg_q <= 8'h00;
                end else if (oam_blocked || !oam_in_range) begin
                  src   <= SRC_REG;
                  reg_q <= 8'hFF;
                end else begin
                  src   <= SRC_OAM;
                end
              end
              TGA_REGS: begin
                if (idx == REG_BCPD) begin
                  src <= SRC_BGPD;
                end else if (idx == REG_OCPD) begin
                  src <= SRC_OBPD;
                end else begin
                  src   <= SRC_REG;
                  reg_q <= reg_rd;
                end
              end
              default: begin
                src   <= SRC_REG;
                reg_q <= 8'hFF;
              end
            endcase
          end
        end
        ST_DMA_COPY: begin
          state      <= ST_IDLE;
          wb_stall_o <= 1'b0;
          wb_ack_o   <= wb_cyc_i;
          src        <= SRC_REG;
          reg_q      <= vram_q;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data mux, steered by the source captured at acceptance
  always_comb begin
    wb_dat_o = 8'h00;
    case (src)
      SRC_REG:  wb_dat_o = reg_q;
      SRC_VRAM: wb_dat_o = vram_q;
      SRC_OAM:  wb_dat_o = oam_q;
      SRC_BGPD: wb_dat_o = bg_data_q;
      SRC_OBPD: wb_dat_o = obj_data_q;
      default:  wb_dat_o = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_gbc_video_memory_target.sv
// ============================================================================
// Module   : tb_gbc_video_memory_target
// Purpose  : Self-checking bench for gbc_video_memory_target; expected acks
//            are queued with their due cycle and data, and checked on arrival.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gbc_video_memory_target;
  import gbc_video_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc, stb, we, tgc;
  logic [13:0] adr;
  logic [7:0]  dat_w;
  logic [1:0]  tga;
  logic [7:0]  dat_r;
  logic        ack, stall;
  logic [1:0]  mode;
  logic [7:0]  ly;
  video_regs_t regs;

  typedef struct {
    int         due;
    logic [7:0] data;
    bit         chk;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   cycle_cnt = 0;

  gbc_video_memory_target #(.VRAM_BANKS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_w),
    .wb_tga_i   (tga),
    .wb_tgc_i   (tgc),
    .wb_dat_o   (dat_r),
    .wb_ack_o   (ack),
    .wb_stall_o (stall),
    .ppu_mode_i (mode),
    .ly_i       (ly),
    .regs_o     (regs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Scoreboard: an ack must arrive exactly on the due cycle of the queue head
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cycle_cnt) begin
      total++;
      if (ack === 1'b1 && (!sb[0].chk || dat_r === sb[0].data)) passed++;
      else $display("FAIL ack_data cycle %0d: ack=%b dat=%h, required ack=1 dat=%h",
                    cycle_cnt, ack, dat_r, sb[0].data);
      void'(sb.pop_front());
    end else if (ack !== 1'b0) begin
      total++;
      $display("FAIL unexpected_ack cycle %0d: ack=%b, required 0", cycle_cnt, ack);
    end
  end

  task automatic issue(input logic [1:0] t, input logic c, input logic w,
                       input logic [13:0] a, input logic [7:0] d,
                       input logic [7:0] e, input bit chk, input int extra);
    cyc = 1'b1; stb = 1'b1; tga = t; tgc = c; we = w; adr = a; dat_w = d;
    if (extra >= 0) sb.push_back('{due: cycle_cnt + 1 + extra, data: e, chk: chk});
    @(negedge clk);
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; tgc = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain: %0d acks outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wr(input logic [1:0] t, input logic c, input logic [13:0] a, input logic [7:0] d);
    issue(t, c, 1'b1, a, d, 8'h00, 1'b0, 0);
    bus_idle();
    drain();
  endtask

  task automatic rd(input logic [1:0] t, input logic [13:0] a, input logic [7:0] e);
    issue(t, 1'b0, 1'b0, a, 8'h00, e, 1'b1, 0);
    bus_idle();
    drain();
  endtask

  task automatic test_reset();
    total++;
    if (ack === 1'b0 && stall === 1'b0 && dat_r === 8'h00) passed++;
    else $display("FAIL reset_bus: ack=%b stall=%b dat=%h, required 0 0 00", ack, stall, dat_r);
    total++;
    if (regs.lcdc === 8'h91 && regs.bgp === 8'hFC && regs.scy === 8'h00 && regs.wx === 8'h00) passed++;
    else $display("FAIL reset_regs: lcdc=%h bgp=%h scy=%h wx=%h, required 91 fc 00 00",
                  regs.lcdc, regs.bgp, regs.scy, regs.wx);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vram();
    mode = 2'd0;
    wr(TGA_VRAM, 1'b0, 14'h0123, 8'h5A);
    rd(TGA_VRAM, 14'h0123, 8'h5A);
    wr(TGA_VRAM, 1'b0, 14'h2123, 8'hC3);
    rd(TGA_VRAM, 14'h0123, 8'h5A);
    rd(TGA_VRAM, 14'h2123, 8'hC3);
    mode = 2'd3;
    rd(TGA_VRAM, 14'h0123, 8'hFF);
    wr(TGA_VRAM, 1'b0, 14'h0123, 8'h00);
    mode = 2'd0;
    rd(TGA_VRAM, 14'h0123, 8'h5A);
    // strobe without cycle must be ignored
    cyc = 1'b0; stb = 1'b1; we = 1'b1; tga = TGA_VRAM; tgc = 1'b0; adr = 14'h0123; dat_w = 8'h00;
    repeat (2) @(negedge clk);
    bus_idle();
    rd(TGA_VRAM, 14'h0123, 8'h5A);
  endtask

  task automatic test_oam();
    mode = 2'd0;
    wr(TGA_OAM, 1'b0, 14'h0010, 8'h77);
    mode = 2'd2;
    rd(TGA_OAM, 14'h0010, 8'hFF);
    issue(TGA_OAM, 1'b1, 1'b1, 14'h0010, 8'h33, 8'h00, 1'b1, 0);
    bus_idle();
    drain();
    mode = 2'd0;
    rd(TGA_OAM, 14'h0010, 8'h33);
    rd(TGA_OAM, 14'h00A0, 8'hFF);
    rd(TGA_OAM, 14'h009F, 8'h00 | 8'h00) ;
  endtask

  task automatic test_dma();
    mode = 2'd0;
    wr(TGA_VRAM, 1'b0, 14'h0005, 8'hA0);
    mode = 2'd3;
    issue(TGA_VRAM, 1'b1, 1'b0, 14'h0005, 8'h00, 8'hA0, 1'b1, 1);
    total++;
    if (stall === 1'b1) passed++;
    else $display("FAIL dma_stall_on: stall=%b, required 1", stall);
    stb = 1'b0;
    @(negedge clk);
    total++;
    if (stall === 1'b0) passed++;
    else $display("FAIL dma_stall_off: stall=%b, required 0", stall);
    bus_idle();
    drain();
    mode = 2'd0;
    rd(TGA_OAM, 14'h0005, 8'hA0);
  endtask

  task automatic test_palette();
    mode = 2'd0;
    wr(TGA_REGS, 1'b0, 14'h0068, 8'hBF);
    wr(TGA_REGS, 1'b0, 14'h0069, 8'h11);
    wr(TGA_REGS, 1'b0, 14'h0069, 8'h22);
    rd(TGA_REGS, 14'h0068, 8'hC1);
    wr(TGA_REGS, 1'b0, 14'h0068, 8'h3F);
    rd(TGA_REGS, 14'h0069, 8'h11);
    wr(TGA_REGS, 1'b0, 14'h0068, 8'h00);
    rd(TGA_REGS, 14'h0069, 8'h22);
    rd(TGA_REGS, 14'h0069, 8'h22);
    rd(TGA_REGS, 14'h0068, 8'h40);
    wr(TGA_REGS, 1'b0, 14'h0068, 8'h05);
    wr(TGA_REGS, 1'b0, 14'h0069, 8'h44);
    wr(TGA_REGS, 1'b0, 14'h0068, 8'h85);
    mode = 2'd3;
    wr(TGA_REGS, 1'b0, 14'h0069, 8'h99);
    rd(TGA_REGS, 14'h0068, 8'hC6);
    rd(TGA_REGS, 14'h0069, 8'hFF);
    mode = 2'd0;
    wr(TGA_REGS, 1'b0, 14'h0068, 8'h05);
    rd(TGA_REGS, 14'h0069, 8'h44);
    wr(TGA_REGS, 1'b0, 14'h006A, 8'h82);
    wr(TGA_REGS, 1'b0, 14'h006B, 8'h5E);
    rd(TGA_REGS, 14'h006A, 8'hC3);
    wr(TGA_REGS, 1'b0, 14'h006A, 8'h02);
    rd(TGA_REGS, 14'h006B, 8'h5E);
  endtask

  task automatic test_regs();
    mode = 2'd1;
    ly   = 8'h20;
    wr(TGA_REGS, 1'b0, 14'h0045, 8'h20);
    wr(TGA_REGS, 1'b0, 14'h0041, 8'h78);
    rd(TGA_REGS, 14'h0041, 8'hFD);
    ly = 8'h21;
    rd(TGA_REGS, 14'h0041, 8'hF9);
    wr(TGA_REGS, 1'b0, 14'h0044, 8'h55);
    rd(TGA_REGS, 14'h0044, 8'h21);
    wr(TGA_REGS, 1'b0, 14'h0043, 8'h12);
    rd(TGA_REGS, 14'h0043, 8'h12);
    total++;
    if (regs.scx === 8'h12 && regs.lyc === 8'h20) passed++;
    else $display("FAIL regs_out: scx=%h lyc=%h, required 12 20", regs.scx, regs.lyc);
    wr(TGA_REGS, 1'b0, 14'h0050, 8'h00);
    rd(TGA_REGS, 14'h0050, 8'hFF);
    wr(TGA_REGS, 1'b0, 14'h0040, 8'h00);
    rd(TGA_REGS, 14'h0040, 8'h00);
    mode = 2'd0;
  endtask

  task automatic test_invalid();
    rd(TGA_INVALID, 14'h0040, 8'hFF);
    issue(TGA_INVALID, 1'b0, 1'b1, 14'h0040, 8'h77, 8'hFF, 1'b1, 0);
    bus_idle();
    drain();
    rd(TGA_REGS, 14'h0040, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [4];
    mode = 2'd0;
    for (int i = 0; i < 4; i++) v[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) issue(TGA_VRAM, 1'b0, 1'b1, 14'(256 + i), v[i], 8'h00, 1'b0, 0);
    for (int i = 0; i < 4; i++) issue(TGA_VRAM, 1'b0, 1'b0, 14'(256 + i), 8'h00, v[i], 1'b1, 0);
    issue(TGA_REGS, 1'b0, 1'b0, 14'h0047, 8'h00, 8'hFC, 1'b1, 0);
    bus_idle();
    drain();
  endtask

  task automatic test_cyc_drop();
    mode = 2'd0;
    wr(TGA_VRAM, 1'b0, 14'h0007, 8'h6B);
    issue(TGA_VRAM, 1'b1, 1'b0, 14'h0007, 8'h00, 8'h00, 1'b0, -1);
    total++;
    if (stall === 1'b1) passed++;
    else $display("FAIL cyc_drop_stall: stall=%b, required 1", stall);
    bus_idle();
    repeat (2) @(negedge clk);
    rd(TGA_OAM, 14'h0007, 8'h6B);
  endtask

  task automatic test_dma_reset();
    mode = 2'd0;
    issue(TGA_OAM, 1'b1, 1'b1, 14'h0009, 8'h12, 8'h00, 1'b1, 0);
    bus_idle();
    drain();
    wr(TGA_VRAM, 1'b0, 14'h0009, 8'h34);
    issue(TGA_VRAM, 1'b1, 1'b0, 14'h0009, 8'h00, 8'h00, 1'b0, -1);
    total++;
    if (stall === 1'b1) passed++;
    else $display("FAIL rst_dma_stall: stall=%b, required 1", stall);
    stb   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (stall === 1'b0 && ack === 1'b0) passed++;
    else $display("FAIL rst_dma_abort: stall=%b ack=%b, required 0 0", stall, ack);
    bus_idle();
    @(negedge clk);
    rd(TGA_OAM, 14'h0009, 8'h12);
    rd(TGA_REGS, 14'h0040, 8'h91);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; tgc = 1'b0;
    adr = '0; dat_w = '0; tga = TGA_VRAM;
    mode = 2'd0; ly = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_vram();
    test_oam();
    test_dma();
    test_palette();
    test_regs();
    test_invalid();
    test_back_to_back();
    test_cyc_drop();
    test_dma_reset();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gbc_video_memory_target.md
GBC_VIDEO_MEMORY_TARGET -- requirements
Module: gbc_video_memory_target

Interface
REQ-001 SHALL have parameter VRAM_BANKS, default 2, meaning the number of 8 KiB VRAM banks (1 or 2).
REQ-002 SHALL have port clk, input, 1, the system clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port wb_cyc_i, input, 1, Wishbone cycle.
REQ-005 SHALL have port wb_stb_i, input, 1, Wishbone strobe.
REQ-006 SHALL have port wb_we_i, input, 1, write enable.
REQ-007 SHALL have port wb_adr_i, input, 14, byte address; bit 13 is the VRAM bank.
REQ-008 SHALL have port wb_dat_i, input, 8, write data.
REQ-009 SHALL have port wb_tga_i, input, 2, address space: 00 VRAM, 01 OAM, 10 registers, 11 invalid.
REQ-010 SHALL have port wb_tgc_i, input, 1, OAM DMA cycle.
REQ-011 SHALL have port wb_dat_o, output, 8, read data.
REQ-012 SHALL have port wb_ack_o, output, 1, acknowledge.
REQ-013 SHALL have port wb_stall_o, output, 1, stall.
REQ-014 SHALL have port ppu_mode_i, input, 2, current PPU mode (0 to 3).
REQ-015 SHALL have port ly_i, input, 8, current scanline.
REQ-016 SHALL have port regs_o, output, video_regs_t, the live register file for the PPU.

Function
REQ-017 A request SHALL be accepted on a cycle with cyc&stb&!stall.
REQ-018 For a non-DMA request accepted at cycle N, ack SHALL be high for exactly one cycle at N+1, with dat_o valid in that cycle.
REQ-019 Stall SHALL be low except as REQ-025 specifies, so back-to-back requests sustain one per cycle.
REQ-020 VRAM (TGA 00, TGC 0) SHALL read or write byte adr[12:0] of bank adr[13].
REQ-021 When VRAM_BANKS=1, adr[13] SHALL be ignored.
REQ-022 When ppu_mode_i==3 at acceptance, a VRAM access SHALL read 0xFF and SHALL drop any write.
REQ-023 OAM (TGA 01, TGC 0) SHALL access index adr[7:0] when that index is <0xA0.
REQ-024 An OAM access SHALL read 0xFF and drop any write when the index is >=0xA0, or when ppu_mode_i is 2 or 3 at acceptance.
REQ-025 DMA SHALL bypass mode blocking.
- TGC 1, TGA 01: write wb_dat_i to OAM[adr[7:0]]; ack at N+1; dat_o 0x00.
- TGC 1, TGA 00: read VRAM[adr], then write that byte to OAM[adr[7:0]]; stall high at N+1; ack at N+2; dat_o = copied byte.
REQ-026 Registers (TGA 10) SHALL be indexed by adr[7:0].
- Read/write: 0x40 LCDC, 0x42 SCY, 0x43 SCX, 0x45 LYC, 0x47 BGP, 0x48 OBP0, 0x49 OBP1, 0x4A WY, 0x4B WX, 0x46 DMA (storage only).
- 0x44 reads ly_i; writes are ignored.
- 0x41 STAT: bits 6:3 writable; bit 7 reads 1; bit 2 reads (ly_i==LYC); bits 1:0 read ppu_mode_i.
- All other indices read 0xFF and ignore writes.
REQ-027 Palette registers SHALL operate as follows.
- 0x68 BCPS / 0x6A OCPS: bit 7 is auto-increment, bits 5:0 are the index; bit 6 reads 1.
- 0x69 BCPD / 0x6B OCPD access the 64-byte BG or OBJ palette RAM at that index.
- A BCPD/OCPD write with auto-increment set SHALL increment the index mod 64 (0x3F wraps to 0x00); reads SHALL not increment.
- During mode 3, BCPD/OCPD reads SHALL return 0xFF and writes SHALL be dropped, but the auto-increment SHALL still apply.
REQ-028 TGA 11 SHALL be acknowledged at N+1 with dat_o 0xFF and no side effects.
REQ-029 A request SHALL not be accepted while cyc is low.
REQ-030 Dropping cyc during a DMA stall SHALL still complete the OAM write, and the ack SHALL be suppressed.

Reset
REQ-031 On reset, ack and stall SHALL be 0 and dat_o SHALL be 0x00.
REQ-032 On reset, LCDC SHALL be 0x91, BGP 0xFC, and all other registers and palette indices 0x00.
REQ-033 Reset SHALL not clear VRAM, OAM or palette RAM.
REQ-034 A reset during a DMA stall SHALL abort the DMA without writing OAM.

Structure
REQ-035 Package gbc_video_pkg SHALL hold video_regs_t, the TGA encodings, the register offset constants and the reset values.
REQ-036 VRAM, OAM and the palettes SHALL be implemented as inferred single-port BRAMs.
REQ-037 One sub-module, gbc_palette_ram, SHALL be instantiated twice (BG and OBJ), owning the index register, auto-increment logic and 64x8 RAM.

Verification
REQ-038 Write VRAM 0x0123=0x5A in mode 0, then read it back -> ack at N+1 both times; read returns 0x5A.
REQ-039 Read OAM 0x10 in mode 2 -> 0xFF; TGC write to OAM 0x10 of 0x33 in mode 2, then read in mode 0 -> 0x33.
REQ-040 VRAM 0x0005=0xA0, then TGC/TGA 00 at adr 0x0005 -> stall for one cycle, ack at N+2 with 0xA0; OAM[5] reads 0xA0.
REQ-041 BCPS=0xBF, write BCPD 0x11 then 0x22 -> palette[0x3F]=0x11, palette[0x00]=0x22; BCPS reads 0xC1.
REQ-042 LYC=0x20, ly_i=0x20, mode 1, STAT written 0x78 -> STAT reads 0xFD; LY write ignored.
REQ-043 Reset asserted during a DMA stall -> no ack; OAM unchanged; LCDC reads 0x91.
